// File: rtl/mem_write_tap_if.sv
// Memory-side request bus plus checker-side valid/ready event stream for mem_write_tap.
// master drives requests and out_ready; slave is the tap.
interface mem_write_tap_if;
  logic        mem_wen;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_stall;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] out_addr;
  logic [31:0] out_data;
  logic [15:0] out_time;

  modport master (
    output mem_wen, mem_addr, mem_wdata, mem_stall, out_ready,
    input  out_valid, out_addr, out_data, out_time
  );

  modport slave (
    input  mem_wen, mem_addr, mem_wdata, mem_stall, out_ready,
    output out_valid, out_addr, out_data, out_time
  );
endinterface

// File: rtl/mem_write_tap.sv
// Captures committed (unstalled) writes into a window of word addresses, time-stamps them
// and queues them in a small FIFO presented to the checker over valid/ready.
module mem_write_tap #(
  parameter int          DEPTH     = 4,
  parameter logic [29:0] PORT_BASE = 30'h0,
  parameter int          PORT_NUM  = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_write_tap_if.slave      bus,
  output logic [15:0]         wr_count,
  output logic [7:0]          drop_count,
  output logic                overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_cycle;
  logic [15:0]     r_wr_count;
  logic [7:0]      r_drop_count;
  logic            r_overflow;
  logic [29:0]     r_addr_q [DEPTH];
  logic [31:0]     r_data_q [DEPTH];
  logic [15:0]     r_time_q [DEPTH];

  logic [29:0]     w_offset;
  logic            w_commit;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  // A stalled request is held stable, so only its unstalled cycle counts as the commit.
  assign w_offset = bus.mem_addr - PORT_BASE;
  assign w_commit = bus.mem_wen && !bus.mem_stall &&
                    (bus.mem_addr >= PORT_BASE) && (w_offset < 30'(PORT_NUM));

  assign bus.out_valid = (r_state != ST_EMPTY);
  assign bus.out_addr  = r_addr_q[r_rd_ptr];
  assign bus.out_data  = r_data_q[r_rd_ptr];
  assign bus.out_time  = r_time_q[r_rd_ptr];
  assign wr_count      = r_wr_count;
  assign drop_count    = r_drop_count;
  assign overflow      = r_overflow;

  // Full + pop frees the head slot in the same cycle, so the new entry still fits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_pop       = bus.out_valid && bus.out_ready;
    w_push      = w_commit && ((r_state != ST_FULL) || w_pop);
    w_drop      = w_commit && (r_state == ST_FULL) && !w_pop;
    case (r_state)
      ST_EMPTY:   if (w_push) w_state_nxt = ST_PARTIAL;
      ST_PARTIAL: begin
        if (w_push && !w_pop && (r_count == CW'(DEPTH - 1)))
          w_state_nxt = ST_FULL;
        else if (w_pop && !w_push && (r_count == CW'(1)))
          w_state_nxt = ST_EMPTY;
      end
      ST_FULL:    if (w_pop && !w_push) w_state_nxt = ST_PARTIAL;
      default:    w_state_nxt = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_EMPTY;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_cycle      <= '0;
      r_wr_count   <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cycle <= r_cycle + 16'd1;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_commit) r_wr_count <= r_wr_count + 16'd1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  // NOTE: storage is reset so the head fields read zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr_q[i] <= '0;
        r_data_q[i] <= '0;
        r_time_q[i] <= '0;
      end
    end else if (w_push) begin
      r_addr_q[r_wr_ptr] <= bus.mem_addr;
      r_data_q[r_wr_ptr] <= bus.mem_wdata;
      r_time_q[r_wr_ptr] <= r_cycle;
    end
  end

endmodule

// File: tb/tb_mem_write_tap.sv
// Directed self-checking bench for mem_write_tap: stall filtering, ordering,
// overflow, full+pop, window filtering and asynchronous reset.
module tb_mem_write_tap;
  logic clk;
  logic rst;
  logic [15:0] wr_count;
  logic [7:0]  drop_count;
  logic        overflow;

  int n_checks;
  int n_errors;
  int cyc;               // edges since the last reset release
  int t_exp[8];

  mem_write_tap_if bus ();

  mem_write_tap #(.DEPTH(4), .PORT_BASE(30'h0), .PORT_NUM(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .wr_count  (wr_count),
    .drop_count(drop_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic wen, input logic [29:0] addr, input logic [31:0] data,
                       input logic stall);
    bus.mem_wen   = wen;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    bus.mem_stall = stall;
  endtask

  task automatic idle();
    drive(1'b0, 30'h0, 32'h0, 1'b0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    #23;
    check("rst_valid",    32'(bus.out_valid), 32'd0);
    check("rst_addr",     32'(bus.out_addr),  32'd0);
    check("rst_data",     bus.out_data,       32'd0);
    check("rst_time",     32'(bus.out_time),  32'd0);
    check("rst_wr_count", 32'(wr_count),      32'd0);
    check("rst_drop",     32'(drop_count),    32'd0);
    check("rst_overflow", 32'(overflow),      32'd0);
    release_reset();

    // Stalled write commits once, on its unstalled cycle.
    bus.out_ready = 1'b1;
    drive(1'b1, 30'h0, 32'd5, 1'b1);
    repeat (3) tick();
    check("stall_no_valid", 32'(bus.out_valid), 32'd0);
    check("stall_no_count", 32'(wr_count),      32'd0);
    bus.mem_stall = 1'b0;
    t_exp[0] = cyc;
    tick();
    idle();
    check("stall_valid", 32'(bus.out_valid), 32'd1);
    check("stall_addr",  32'(bus.out_addr),  32'd0);
    check("stall_data",  bus.out_data,       32'd5);
    check("stall_time",  32'(bus.out_time),  32'(t_exp[0]));
    check("stall_count", 32'(wr_count),      32'd1);
    tick();
    check("stall_one_cycle", 32'(bus.out_valid), 32'd0);

    // Out-of-window write and reads are invisible.
    bus.out_ready = 1'b0;
    drive(1'b1, 30'h10, 32'hDEAD, 1'b0);
    tick();
    drive(1'b0, 30'h0, 32'hBEEF, 1'b0);
    repeat (2) tick();
    check("filter_valid", 32'(bus.out_valid), 32'd0);
    check("filter_count", 32'(wr_count),      32'd1);

    // Three consecutive writes queue in order, then drain one per cycle.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 30'(i), 32'd4, 1'b0);
      t_exp[i] = cyc;
      tick();
    end
    idle();
    check("seq_count", 32'(wr_count), 32'd4);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("seq_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("seq_addr%0d", i),  32'(bus.out_addr),  32'(i));
      check($sformatf("seq_data%0d", i),  bus.out_data,       32'd4);
      check($sformatf("seq_time%0d", i),  32'(bus.out_time),  32'(t_exp[1] + i - 1));
      tick();
    end
    check("seq_drained", 32'(bus.out_valid), 32'd0);

    // Six commits into a depth-4 FIFO: first four kept, two dropped.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 30'(i % 4), 32'(100 + i), 1'b0);
      t_exp[i] = cyc;
      tick();
    end
    idle();
    check("ovf_count",    32'(wr_count),   32'd10);
    check("ovf_drop",     32'(drop_count), 32'd2);
    check("ovf_sticky",   32'(overflow),   32'd1);
    check("ovf_head",     bus.out_data,    32'd100);

    // Full + commit + pop in the same cycle: no drop, new entry goes last.
    bus.out_ready = 1'b1;
    drive(1'b1, 30'h2, 32'd200, 1'b0);
    t_exp[4] = cyc;
    tick();
    idle();
    check("fullpop_drop",  32'(drop_count), 32'd2);
    check("fullpop_count", 32'(wr_count),   32'd11);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("fullpop_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("fullpop_data%0d", i),  bus.out_data, (i == 4) ? 32'd200 : 32'(100 + i));
      check($sformatf("fullpop_time%0d", i),  32'(bus.out_time), 32'(t_exp[i]));
      tick();
    end
    check("fullpop_empty", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset with three entries queued.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 30'(i), 32'(50 + i), 1'b0);
      tick();
    end
    idle();
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("areset_valid",    32'(bus.out_valid), 32'd0);
    check("areset_wr_count", 32'(wr_count),      32'd0);
    check("areset_drop",     32'(drop_count),    32'd0);
    check("areset_overflow", 32'(overflow),      32'd0);
    release_reset();
    repeat (4) tick();
    drive(1'b1, 30'h3, 32'd9, 1'b0);
    tick();
    idle();
    check("post_reset_valid", 32'(bus.out_valid), 32'd1);
    check("post_reset_time",  32'(bus.out_time),  32'd4);
    check("post_reset_data",  bus.out_data,       32'd9);
    check("post_reset_count", 32'(wr_count),      32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
